etc_kloop_ctrl: RTL

Sequencer that drives one `etc` 4x4 tensor-core instance through a K-dimension reduction. It accepts a stream of `ktiles` (A,B) 4x4 tile pairs, issues one pair per cycle to `etc`, and tracks `etc`'s fixed 2-cycle latency. It accumulates the returned 4x4 products into a W-bit accumulator and presents the final C = sum(A_k*B_k) tile on a valid/ready result port. It sits between the tile fetch logic and the `etc` datapath. `etc` is instantiated outside this block and connected through the `etc_*` ports.

---
 rtl/etc_kloop_ctrl_if.sv | 29 ++
 rtl/etc_kloop_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/etc_kloop_ctrl_if.sv
// etc_kloop_ctrl_if: tile stream, etc operand/product and result handshake bundle
interface etc_kloop_ctrl_if #(
    parameter int W  = 16,
    parameter int CW = 8
);
    logic                   start;
    logic [CW-1:0]          ktiles;
    logic                   tile_valid;
    logic                   tile_ready;
    logic [3:0][3:0][W-1:0] tileA;
    logic [3:0][3:0][W-1:0] tileB;
    logic [3:0][3:0][W-1:0] etc_inA;
    logic [3:0][3:0][W-1:0] etc_inB;
    logic [3:0][3:0][W-1:0] etc_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [3:0][3:0][W-1:0] res;
    logic                   busy;

    modport master (
        input  start, ktiles, tile_valid, tileA, tileB, etc_out, res_ready,
        output tile_ready, etc_inA, etc_inB, res_valid, res, busy
    );

    modport slave (
        output start, ktiles, tile_valid, tileA, tileB, etc_out, res_ready,
        input  tile_ready, etc_inA, etc_inB, res_valid, res, busy
    );
endinterface

// File: rtl/etc_kloop_ctrl.sv
// etc_kloop_ctrl: feeds K tile pairs through a 2-cycle etc core and accumulates C = sum(A_k*B_k)
module etc_kloop_ctrl #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input logic clk,
    input logic rst,
    etc_kloop_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          kreg;
    logic [CW-1:0]          issued;
    logic [CW-1:0]          retired;
    logic [CW-1:0]          retiredNext;
    logic [1:0]             vpipe;
    logic [3:0][3:0][W-1:0] acc;
    logic [3:0][3:0][W-1:0] accSum;
    logic                   tileReady;
    logic                   resValid;
    logic                   busyReg;
    logic                   issue;

    assign issue         = bus.tile_valid & tileReady;
    assign bus.tile_ready = tileReady;
    assign bus.res_valid  = resValid;
    assign bus.busy       = busyReg;
    assign bus.res        = acc;
    assign bus.etc_inA    = issue ? bus.tileA : '0;
    assign bus.etc_inB    = issue ? bus.tileB : '0;
    // counting the retire happening this cycle lets DONE follow the last product immediately
    assign retiredNext    = retired + CW'(vpipe[1]);

    // element-wise wrapping sum of the accumulator and the current etc product
    always_comb begin
        accSum = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                accSum[i][j] = acc[i][j] + bus.etc_out[i][j];
    end

    // sequencer: in-flight tracking, accumulation and state/handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tileReady <= 1'b0;
            resValid  <= 1'b0;
            busyReg   <= 1'b0;
            kreg      <= '0;
            issued    <= '0;
            retired   <= '0;
            vpipe     <= '0;
            acc       <= '0;
        end else begin
            vpipe <= {vpipe[0], issue};
            if (vpipe[1]) begin
                acc     <= accSum;
                retired <= retiredNext;
            end
            case (state)
                IDLE: if (bus.start) begin
                    kreg      <= bus.ktiles;
                    acc       <= '0;
                    issued    <= '0;
                    retired   <= '0;
                    vpipe     <= '0;
                    busyReg   <= 1'b1;
                    tileReady <= bus.ktiles != '0;
                    resValid  <= bus.ktiles == '0;
                    state     <= (bus.ktiles == '0) ? DONE : FEED;
                end
                FEED: if (issue) begin
                    issued <= issued + CW'(1);
                    if (issued + CW'(1) == kreg) begin
                        tileReady <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: if (retiredNext == kreg) begin
                    resValid <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (bus.res_ready) begin
                    resValid <= 1'b0;
                    busyReg  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
